// File: rtl/id_ex_forward_stage.sv
// ID->EX pipeline register with operand forwarding, load-use stall and flush.
// Optional stall-cycle counter is built when STALL_CNT_EN is defined.
module id_ex_forward_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_dest,
    input  logic [CW-1:0] id_ctrl,
    input  logic          hazard_free,
    input  logic [1:0]    vsrc1_sel,
    input  logic [1:0]    vsrc2_sel,
    input  logic [DW-1:0] ex_fwd_val,
    input  logic [DW-1:0] mem_fwd_val,
    input  logic [DW-1:0] wb_fwd_val,
    input  logic          ex_allowin,
    input  logic          flush,
    output logic          id_allowin,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_src1,
    output logic [DW-1:0] ex_src2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_dest,
    output logic [CW-1:0] ex_ctrl,
    output logic [31:0]   stall_cnt
);

    function automatic logic [DW-1:0] fwd_mux(
        input logic [1:0]    sel,
        input logic [DW-1:0] rf_val,
        input logic [DW-1:0] ex_val,
        input logic [DW-1:0] mem_val,
        input logic [DW-1:0] wb_val
    );
        logic [DW-1:0] r;
        case (sel)
            2'd0:    r = rf_val;
            2'd1:    r = ex_val;
            2'd2:    r = mem_val;
            2'd3:    r = wb_val;
            default: r = rf_val;
        endcase
        return r;
    endfunction

    logic          id_ready_go_s;
    logic          id_to_ex_s;
    logic [DW-1:0] src1_s;
    logic [DW-1:0] src2_s;

    logic          ex_valid_q, ex_valid_d;
    logic [DW-1:0] ex_pc_q,   ex_pc_d;
    logic [DW-1:0] ex_src1_q, ex_src1_d;
    logic [DW-1:0] ex_src2_q, ex_src2_d;
    logic [DW-1:0] ex_imm_q,  ex_imm_d;
    logic [4:0]    ex_dest_q, ex_dest_d;
    logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;

    assign id_ready_go_s = hazard_free;
    assign id_to_ex_s    = id_valid & id_ready_go_s & ~flush;
    assign id_allowin    = flush | ~id_valid | (id_ready_go_s & ex_allowin);
    assign src1_s        = fwd_mux(vsrc1_sel, id_rs_val, ex_fwd_val, mem_fwd_val, wb_fwd_val);
    assign src2_s        = fwd_mux(vsrc2_sel, id_rt_val, ex_fwd_val, mem_fwd_val, wb_fwd_val);

    // EX register next state: flush kills, take loads (or bubbles), else hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_src1_d  = ex_src1_q;
        ex_src2_d  = ex_src2_q;
        ex_imm_d   = ex_imm_q;
        ex_dest_d  = ex_dest_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_allowin) begin
            ex_valid_d = id_to_ex_s;
            if (id_to_ex_s) begin
                ex_pc_d   = id_pc;
                ex_src1_d = src1_s;
                ex_src2_d = src2_s;
                ex_imm_d  = id_imm;
                ex_dest_d = id_dest;
                ex_ctrl_d = id_ctrl;
            end else begin
                ex_pc_d   = ex_pc_q;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // EX pipeline register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= {DW{1'b0}};
            ex_src1_q  <= {DW{1'b0}};
            ex_src2_q  <= {DW{1'b0}};
            ex_imm_q   <= {DW{1'b0}};
            ex_dest_q  <= 5'd0;
            ex_ctrl_q  <= {CW{1'b0}};
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_src1_q  <= ex_src1_d;
            ex_src2_q  <= ex_src2_d;
            ex_imm_q   <= ex_imm_d;
            ex_dest_q  <= ex_dest_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_pc_q;
    assign ex_src1  = ex_src1_q;
    assign ex_src2  = ex_src2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_dest  = ex_dest_q;
    assign ex_ctrl  = ex_ctrl_q;

`ifdef STALL_CNT_EN
    // A flush in the same cycle is counted as a flush, never as a stall.
    logic        stall_s;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_s = id_valid & ~hazard_free & ex_allowin & ~flush;

    // Stall counter next state; wraps naturally at 32 bits.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Scoreboard bench for id_ex_forward_stage: directed vectors push expected EX
// contents; a monitor pops and compares whenever a fresh EX load is visible.
module tb_id_ex_forward_stage;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] s1;
        logic [DW-1:0] s2;
        logic [DW-1:0] imm;
        logic [4:0]    dest;
        logic [CW-1:0] ctrl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rs_val, id_rt_val, id_imm;
    logic [4:0]    id_dest;
    logic [CW-1:0] id_ctrl;
    logic          hazard_free;
    logic [1:0]    vsrc1_sel, vsrc2_sel;
    logic [DW-1:0] ex_fwd_val, mem_fwd_val, wb_fwd_val;
    logic          ex_allowin, flush;
    logic          id_allowin, ex_valid;
    logic [DW-1:0] ex_pc, ex_src1, ex_src2, ex_imm;
    logic [4:0]    ex_dest;
    logic [CW-1:0] ex_ctrl;
    logic [31:0]   stall_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic ld_r = 1'b0;

`ifdef STALL_CNT_EN
    localparam logic [31:0] STALLS_EXP = 32'd2;
`else
    localparam logic [31:0] STALLS_EXP = 32'd0;
`endif

    id_ex_forward_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_dest(id_dest), .id_ctrl(id_ctrl), .hazard_free(hazard_free),
        .vsrc1_sel(vsrc1_sel), .vsrc2_sel(vsrc2_sel), .ex_fwd_val(ex_fwd_val),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .ex_allowin(ex_allowin), .flush(flush), .id_allowin(id_allowin),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_dest(ex_dest),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                          input logic hf, input logic [1:0] s1, input logic [1:0] s2);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_rs_val   = rs;
        id_rt_val   = rt;
        id_imm      = pc + 32'h1000;
        id_dest     = pc[6:2];
        id_ctrl     = pc[15:0] ^ 16'hA5A5;
        hazard_free = hf;
        vsrc1_sel   = s1;
        vsrc2_sel   = s2;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2);
        exp_t e;
        e.pc   = pc;
        e.s1   = s1;
        e.s2   = s2;
        e.imm  = pc + 32'h1000;
        e.dest = pc[6:2];
        e.ctrl = pc[15:0] ^ 16'hA5A5;
        sb_q.push_back(e);
    endtask

    // Remember whether the edge just taken was one where EX was allowed to load.
    always @(posedge clk) begin
        ld_r <= ex_allowin & ~flush & ~rst;
    end

    // Monitor: a valid EX register right after a load edge is a new transaction.
    always @(negedge clk) begin
        exp_t e;
        if (ld_r && ex_valid && !rst) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pc", ex_pc, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc",   ex_pc,   e.pc);
                check("sb_src1", ex_src1, e.s1);
                check("sb_src2", ex_src2, e.s2);
                check("sb_imm",  ex_imm,  e.imm);
                check("sb_dest", {27'd0, ex_dest}, {27'd0, e.dest});
                check("sb_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_pc = 32'd0; id_rs_val = 32'd0; id_rt_val = 32'd0;
        id_imm = 32'd0; id_dest = 5'd0; id_ctrl = 16'd0; hazard_free = 1'b1;
        vsrc1_sel = 2'd0; vsrc2_sel = 2'd0; ex_fwd_val = 32'd0; mem_fwd_val = 32'd0;
        wb_fwd_val = 32'd0; ex_allowin = 1'b1; flush = 1'b0;
        #1;
        check("rst_ex_valid",   {31'd0, ex_valid}, 32'd0);
        check("rst_ex_pc",      ex_pc, 32'd0);
        check("rst_ex_src1",    ex_src1, 32'd0);
        check("rst_stall_cnt",  stall_cnt, 32'd0);
        check("rst_id_allowin", {31'd0, id_allowin}, 32'd1);
        tick; tick;
        rst = 1'b0;

        // No hazard, register-file operands.
        set_id(32'h10, 32'h11, 32'h22, 1'b1, 2'd0, 2'd0);
        #1 check("nohaz_id_allowin", {31'd0, id_allowin}, 32'd1);
        push(32'h10, 32'h11, 32'h22);
        tick;
        // EX and WB forwarding.
        set_id(32'h14, 32'h1, 32'h2, 1'b1, 2'd1, 2'd3);
        ex_fwd_val = 32'hAA; wb_fwd_val = 32'hCC;
        push(32'h14, 32'hAA, 32'hCC);
        tick;
        // MEM forwarding on rs.
        set_id(32'h18, 32'h3, 32'h44, 1'b1, 2'd2, 2'd0);
        mem_fwd_val = 32'hBB;
        push(32'h18, 32'hBB, 32'h44);
        tick;

        // Load-use stall for two cycles, then release with a fresh MEM value.
        set_id(32'h1C, 32'h3, 32'h4, 1'b0, 2'd2, 2'd1);
        mem_fwd_val = 32'h5; ex_fwd_val = 32'h77;
        #1 check("stall_id_allowin", {31'd0, id_allowin}, 32'd0);
        tick;
        check("stall1_ex_valid", {31'd0, ex_valid}, 32'd0);
        tick;
        check("stall2_ex_valid", {31'd0, ex_valid}, 32'd0);
        hazard_free = 1'b1; mem_fwd_val = 32'h9;
        #1 check("release_id_allowin", {31'd0, id_allowin}, 32'd1);
        push(32'h1C, 32'h9, 32'h77);
        tick;
        check("stall_cnt_after", stall_cnt, STALLS_EXP);
        id_valid = 1'b0;

        // Backpressure holds EX contents and blocks ID.
        set_id(32'h100, 32'h200, 32'h300, 1'b1, 2'd0, 2'd0);
        push(32'h100, 32'h200, 32'h300);
        tick;
        set_id(32'h104, 32'h204, 32'h304, 1'b1, 2'd0, 2'd0);
        ex_allowin = 1'b0;
        #1 check("bp_id_allowin", {31'd0, id_allowin}, 32'd0);
        tick;
        check("bp_hold_pc", ex_pc, 32'h100);
        check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
        tick;
        check("bp_hold_src1", ex_src1, 32'h200);
        ex_allowin = 1'b1;
        #1 check("bp_release_id_allowin", {31'd0, id_allowin}, 32'd1);
        push(32'h104, 32'h204, 32'h304);
        tick;

        // Flush during stall and backpressure.
        set_id(32'h108, 32'h5, 32'h6, 1'b0, 2'd0, 2'd0);
        ex_allowin = 1'b0; flush = 1'b1;
        #1 check("flush_id_allowin", {31'd0, id_allowin}, 32'd1);
        tick;
        check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_keeps_pc", ex_pc, 32'h104);
        check("flush_stall_cnt", stall_cnt, STALLS_EXP);
        flush = 1'b0; id_valid = 1'b0; ex_allowin = 1'b1;
        tick;

        // Asynchronous reset between edges while EX holds a valid instruction.
        set_id(32'h40, 32'h41, 32'h42, 1'b1, 2'd0, 2'd0);
        push(32'h40, 32'h41, 32'h42);
        tick;
        id_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_ex_src1",  ex_src1, 32'd0);
        check("arst_ex_pc",    ex_pc, 32'd0);
        check("arst_stall_cnt", stall_cnt, 32'd0);
        tick;
        rst = 1'b0;
        set_id(32'h10, 32'h11, 32'h22, 1'b1, 2'd0, 2'd0);
        push(32'h10, 32'h11, 32'h22);
        tick;
        check("resume_ex_valid", {31'd0, ex_valid}, 32'd1);
        id_valid = 1'b0;
        tick; tick;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
